// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider (34-cycle fixed latency) with a start/ready pulse handshake.
// Compile with DIV_SIGNED_EN for two's-complement operands and overflow detection; unsigned otherwise.
module div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic [31:0] data_remainder,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        isBusy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_quo, r_rem, r_divisor, r_opA;
  logic [31:0] r_result, r_remout;
  logic        r_exc, r_dz;
  logic [4:0]  r_cnt;
  logic        w_start;
  logic [32:0] w_shift, w_trial;
  logic [31:0] w_absA, w_absB, w_fix_q, w_fix_r;
  logic        w_fix_e;
`ifdef DIV_SIGNED_EN
  logic        r_negQ, r_negR, r_ovf;
`endif

  assign w_start = ctrl_DIV && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ctrl_DIV) w_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = ctrl_DIV ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    data_resultRDY = (r_state == S_DONE);
    isBusy         = (r_state == S_RUN) || (r_state == S_FIX);
  end

`ifdef DIV_SIGNED_EN
  assign w_absA = data_operandA[31] ? -data_operandA : data_operandA;
  assign w_absB = data_operandB[31] ? -data_operandB : data_operandB;
`else
  assign w_absA = data_operandA;
  assign w_absB = data_operandB;
`endif

  // 33-bit trial: shifted remainder can exceed 32 bits when the divisor is large
  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - {1'b0, r_divisor};

  always_comb begin
    w_fix_q = r_quo;
    w_fix_r = r_rem;
    w_fix_e = 1'b0;
`ifdef DIV_SIGNED_EN
    if (r_negQ) w_fix_q = -r_quo;
    if (r_negR) w_fix_r = -r_rem;
    if (r_ovf) begin
      w_fix_q = 32'h8000_0000;
      w_fix_r = '0;
      w_fix_e = 1'b1;
    end
`endif
    if (r_dz) begin
      w_fix_q = '0;
      w_fix_r = r_opA;
      w_fix_e = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_opA     <= '0;
      r_dz      <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_remout  <= '0;
      r_exc     <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else if (w_start) begin
      r_quo     <= w_absA;
      r_divisor <= w_absB;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_opA     <= data_operandA;
      r_dz      <= (data_operandB == '0);
`ifdef DIV_SIGNED_EN
      r_negQ    <= data_operandA[31] ^ data_operandB[31];
      r_negR    <= data_operandA[31];
      r_ovf     <= (data_operandA == 32'h8000_0000) && (data_operandB == '1);
`endif
    end else if (r_state == S_RUN) begin
      r_rem <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
      r_quo <= {r_quo[30:0], ~w_trial[32]};
      r_cnt <= r_cnt + 5'd1;
    end else if (r_state == S_FIX) begin
      r_result <= w_fix_q;
      r_remout <= w_fix_r;
      r_exc    <= w_fix_e;
    end
  end

  assign data_result    = r_result;
  assign data_remainder = r_remout;
  assign data_exception = r_exc;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, reset/handshake corner sequences,
// and randomized operands against an arithmetic reference model (follows DIV_SIGNED_EN).
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] opA, opB;
  logic        ctrl;
  logic [31:0] res, rem;
  logic        exc, rdy, busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
  } vec_t;

  vec_t tbl[11];

  div_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .ctrl_DIV       (ctrl),
    .data_result    (res),
    .data_remainder (rem),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .isBusy         (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0; r = a; e = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0; e = 1'b1;
      end else begin
        q = sa / sb; r = sa % sb; e = 1'b0;
      end
`else
      q = a / b; r = a % b; e = 1'b0;
`endif
    end
  endtask

  // One division from start edge E0 through E34, checking busy/rdy every cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ee,
                        input bit pre, input bit noise, input bit chain,
                        input logic [31:0] na, input logic [31:0] nb);
    if (!pre) begin
      opA = a; opB = b; ctrl = 1'b1;
      @(posedge clock); #1;
    end
    ctrl = 1'b0; opA = $urandom; opB = $urandom;
    check("busy_rdy_e0", {30'd0, busy, rdy}, 32'd2);
    for (int k = 1; k <= 32; k++) begin
      if (noise && k >= 3 && k <= 6) begin
        ctrl = 1'b1; opA = $urandom; opB = $urandom;
      end else begin
        ctrl = 1'b0;
      end
      @(posedge clock); #1;
      check("busy_rdy_run", {30'd0, busy, rdy}, 32'd2);
    end
    ctrl = noise;
    @(posedge clock); #1;
    check("busy_rdy_done", {30'd0, busy, rdy}, 32'd1);
    check("quotient", res, eq);
    check("remainder", rem, er);
    check("exception", {31'd0, exc}, {31'd0, ee});
    ctrl = chain;
    if (chain) begin opA = na; opB = nb; end
    @(posedge clock); #1;
    check("busy_rdy_after", {30'd0, busy, rdy}, chain ? 32'd2 : 32'd0);
    ctrl = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, q, r;
    logic        e;
    int          seen;

    tbl[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    tbl[1] = '{32'd5, 32'd0, 32'd0, 32'd5, 1'b1};
    tbl[2] = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    tbl[3] = '{32'd7, 32'd100, 32'd0, 32'd7, 1'b0};
    tbl[4] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
    tbl[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0};
    tbl[6] = '{32'd0, 32'd0, 32'd0, 32'd0, 1'b1};
`ifdef DIV_SIGNED_EN
    tbl[7]  = '{32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    tbl[8]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1};
    tbl[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 1'b0};
    tbl[10] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0};
`else
    tbl[7]  = '{32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0};
    tbl[8]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
    tbl[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0};
    tbl[10] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFF9, 1'b0};
`endif

    reset = 1'b1; ctrl = 1'b0; opA = '0; opB = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_result", res, 32'd0);
    check("rst_remainder", rem, 32'd0);
    check("rst_exception", {31'd0, exc}, 32'd0);
    check("rst_rdy", {31'd0, rdy}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 11; i++)
      do_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].e, 1'b0, 1'b0, 1'b0, '0, '0);

    // start requests during RUN/FIX are dropped; start held in DONE chains a new division
    do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 32'd20, 32'd6);
    do_div(32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);

    // reset at E10 aborts the division with no RDY pulse
    opA = 32'd100; opB = 32'd7; ctrl = 1'b1;
    @(posedge clock); #1;
    ctrl = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_result", res, 32'd0);
    check("abort_remainder", rem, 32'd0);
    check("abort_exception", {31'd0, exc}, 32'd0);
    check("abort_rdy", {31'd0, rdy}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (rdy) seen++;
    end
    check("abort_no_rdy", seen, 32'd0);
    do_div(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // reset and start on the same edge: start is dropped
    opA = 32'd9; opB = 32'd3; ctrl = 1'b1; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; ctrl = 1'b0;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    check("rst_start_busy2", {31'd0, busy}, 32'd0);
    check("rst_start_result", res, 32'd0);

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = $urandom_range(0, 2);
        3: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom; end
      endcase
      ref_div(a, b, q, r, e);
      do_div(a, b, q, r, e, 1'b0, 1'b0, 1'b0, '0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
